// File: rtl/plen_arbiter.sv
// Packet-length merge: per-port FIFOs with drop counters feeding a round-robin
// arbiter that emits one registered length per cycle to the counter block.
module plen_arbiter #(
  parameter int NPORTS     = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int DROP_W     = 32
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [NPORTS*16-1:0]       in_tdata,
  input  logic [NPORTS-1:0]          in_tvalid,
  input  logic [NPORTS-1:0]          in_tuser,
  input  logic                       enable,
  input  logic                       clear_drops,
  output logic [15:0]                plen_tdata,
  output logic                       plen_tvalid,
  output logic                       plen_tuser,
  output logic [$clog2(NPORTS)-1:0]  plen_tport,
  output logic [NPORTS*DROP_W-1:0]   drop_count
);

  localparam int PW = $clog2(NPORTS);
  localparam int AW = $clog2(FIFO_DEPTH);

  // Handshake: neither side has a ready. An input beat is taken whenever
  // in_tvalid is high (stored, or counted as a drop if its FIFO stays full);
  // an output beat is presented for exactly one cycle while plen_tvalid is high.

  logic [16:0]       mem_q    [NPORTS][FIFO_DEPTH];
  logic [16:0]       mem_d    [NPORTS][FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q [NPORTS];
  logic [AW-1:0]     wr_ptr_d [NPORTS];
  logic [AW-1:0]     rd_ptr_q [NPORTS];
  logic [AW-1:0]     rd_ptr_d [NPORTS];
  logic [AW:0]       cnt_q    [NPORTS];
  logic [AW:0]       cnt_d    [NPORTS];
  logic [DROP_W-1:0] drop_q   [NPORTS];
  logic [DROP_W-1:0] drop_d   [NPORTS];
  logic [PW-1:0]     last_q, last_d;

  logic              gnt_valid;
  logic [PW-1:0]     gnt_port;
  logic [NPORTS-1:0] pop, push, full;
  int                idx;

  logic              tvalid_q, tvalid_d;
  logic [15:0]       tdata_q, tdata_d;
  logic              tuser_q, tuser_d;
  logic [PW-1:0]     tport_q, tport_d;

  // Round-robin search starts one past the last granted port.
  always_comb begin
    gnt_valid = 1'b0;
    gnt_port  = '0;
    idx       = 0;
    for (int i = 1; i <= NPORTS; i++) begin
      idx = int'(last_q) + i;
      if (idx >= NPORTS) idx = idx - NPORTS;
      if (enable && !gnt_valid && (cnt_q[idx] != '0)) begin
        gnt_valid = 1'b1;
        gnt_port  = PW'(idx);
      end
    end
  end

  always_comb begin
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    drop_d     = drop_q;
    pop        = '0;
    push       = '0;
    full       = '0;
    drop_count = '0;
    for (int p = 0; p < NPORTS; p++) begin
      full[p] = (cnt_q[p] == (AW+1)'(FIFO_DEPTH));
      pop[p]  = gnt_valid && (gnt_port == PW'(p));
      // A full FIFO still accepts when its head leaves in the same cycle.
      push[p] = in_tvalid[p] && (!full[p] || pop[p]);
      if (push[p]) begin
        mem_d[p][wr_ptr_q[p]] = {in_tuser[p], in_tdata[16*p +: 16]};
        wr_ptr_d[p]           = wr_ptr_q[p] + 1'b1;
      end
      if (pop[p]) rd_ptr_d[p] = rd_ptr_q[p] + 1'b1;
      if (push[p] && !pop[p])      cnt_d[p] = cnt_q[p] + 1'b1;
      else if (pop[p] && !push[p]) cnt_d[p] = cnt_q[p] - 1'b1;
      if (clear_drops)
        drop_d[p] = '0;
      else if (in_tvalid[p] && full[p] && !pop[p] && (drop_q[p] != '1))
        drop_d[p] = drop_q[p] + 1'b1;
      drop_count[DROP_W*p +: DROP_W] = drop_q[p];
    end
  end

  always_comb begin
    tvalid_d = gnt_valid;
    tdata_d  = tdata_q;
    tuser_d  = tuser_q;
    tport_d  = tport_q;
    last_d   = last_q;
    if (gnt_valid) begin
      {tuser_d, tdata_d} = mem_q[gnt_port][rd_ptr_q[gnt_port]];
      tport_d            = gnt_port;
      last_d             = gnt_port;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      for (int p = 0; p < NPORTS; p++) begin
        wr_ptr_q[p] <= '0;
        rd_ptr_q[p] <= '0;
        cnt_q[p]    <= '0;
        drop_q[p]   <= '0;
      end
      last_q   <= PW'(NPORTS-1);
      tvalid_q <= 1'b0;
      tdata_q  <= '0;
      tuser_q  <= 1'b0;
      tport_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      drop_q   <= drop_d;
      last_q   <= last_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      tuser_q  <= tuser_d;
      tport_q  <= tport_d;
    end
  end

  // Storage needs no reset: occupancy counts alone decide what is valid.
  always_ff @(posedge clk) mem_q <= mem_d;

  assign plen_tvalid = tvalid_q;
  assign plen_tdata  = tdata_q;
  assign plen_tuser  = tuser_q;
  assign plen_tport  = tport_q;

endmodule

// File: tb/tb_plen_arbiter.sv
// Bench for plen_arbiter: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_plen_arbiter;
  localparam int NP = 4;
  localparam int DEPTH = 4;
  localparam int DW = 4;

  logic              clk = 1'b0;
  logic              resetn = 1'b0;
  logic [NP*16-1:0]  in_tdata = '0;
  logic [NP-1:0]     in_tvalid = '0;
  logic [NP-1:0]     in_tuser = '0;
  logic              enable = 1'b0;
  logic              clear_drops = 1'b0;
  logic [15:0]       plen_tdata;
  logic              plen_tvalid;
  logic              plen_tuser;
  logic [1:0]        plen_tport;
  logic [NP*DW-1:0]  drop_count;

  plen_arbiter #(.NPORTS(NP), .FIFO_DEPTH(DEPTH), .DROP_W(DW)) dut (
    .clk(clk), .resetn(resetn), .in_tdata(in_tdata), .in_tvalid(in_tvalid),
    .in_tuser(in_tuser), .enable(enable), .clear_drops(clear_drops),
    .plen_tdata(plen_tdata), .plen_tvalid(plen_tvalid), .plen_tuser(plen_tuser),
    .plen_tport(plen_tport), .drop_count(drop_count)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // reference model: one queue per port, pointer as a plain integer
  logic [16:0] exp_q [NP][$];
  int          m_last;
  logic        m_valid;
  logic [15:0] m_data;
  logic        m_user;
  int          m_port;
  int          m_drop [NP];
  int          mp;
  logic [16:0] me;

  always @(posedge clk) begin
    if (!resetn) begin
      for (int p = 0; p < NP; p++) begin
        exp_q[p].delete();
        m_drop[p] = 0;
      end
      m_last = NP-1; m_valid = 0; m_data = 0; m_user = 0; m_port = 0;
    end else begin
      m_valid = 0;
      if (enable) begin
        for (int i = 1; i <= NP; i++) begin
          mp = (m_last + i) % NP;
          if (!m_valid && exp_q[mp].size() > 0) begin
            me = exp_q[mp].pop_front();
            m_valid = 1; m_data = me[15:0]; m_user = me[16]; m_port = mp; m_last = mp;
          end
        end
      end
      for (int p = 0; p < NP; p++) begin
        if (in_tvalid[p]) begin
          if (exp_q[p].size() < DEPTH) exp_q[p].push_back({in_tuser[p], in_tdata[16*p +: 16]});
          else if (m_drop[p] < (1 << DW) - 1) m_drop[p]++;
        end
        if (clear_drops) m_drop[p] = 0;
      end
    end
  end

  // scoreboard compare, every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_valid", plen_tvalid, m_valid);
      chk("m_tdata", plen_tdata, m_data);
      chk("m_tuser", plen_tuser, m_user);
      chk("m_tport", plen_tport, m_port);
      for (int p = 0; p < NP; p++) chk("m_drop", drop_count[DW*p +: DW], m_drop[p]);
    end
  end

  // driver tasks
  task automatic drive(input int p, input int d, input bit u);
    in_tvalid = '0;
    in_tvalid[p] = 1'b1;
    in_tdata[16*p +: 16] = d[15:0];
    in_tuser[p] = u;
  endtask

  task automatic idle();
    in_tvalid = '0;
    in_tuser = '0;
    clear_drops = 1'b0;
  endtask

  task automatic do_reset();
    idle();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
  endtask

  int exp34 [5] = '{10, 11, 12, 13, 77};

  initial begin
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_valid", plen_tvalid, 0);
    chk("rst_tdata", plen_tdata, 0);
    chk("rst_tport", plen_tport, 0);
    chk("rst_drop", drop_count, 0);
    resetn = 1'b1; enable = 1'b1;
    @(negedge clk);

    // single pulse, two-clock latency
    drive(2, 64, 0);
    @(negedge clk); idle();
    chk("t31_early", plen_tvalid, 0);
    @(negedge clk);
    chk("t31_valid", plen_tvalid, 1);
    chk("t31_tdata", plen_tdata, 64);
    chk("t31_tuser", plen_tuser, 0);
    chk("t31_tport", plen_tport, 2);
    chk("t31_drop", drop_count, 0);
    @(negedge clk);
    chk("t31_oneshot", plen_tvalid, 0);

    // simultaneous bursts from reset
    do_reset();
    for (int b = 0; b < 2; b++) begin
      in_tvalid = 4'hF; in_tuser = '0;
      in_tdata = {16'd400, 16'd300, 16'd200, 16'd100};
      @(negedge clk); idle();
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        chk("t32_valid", plen_tvalid, 1);
        chk("t32_tport", plen_tport, i);
        chk("t32_tdata", plen_tdata, 100 * (i + 1));
      end
      @(negedge clk);
      chk("t32_gap", plen_tvalid, 0);
    end

    // halted arbitration: overflow then resume
    enable = 1'b0;
    for (int d = 1; d <= 6; d++) begin
      drive(1, d, 0);
      @(negedge clk);
    end
    idle();
    chk("t33_drop1", drop_count[DW*1 +: DW], 2);
    chk("t33_halted", plen_tvalid, 0);
    enable = 1'b1;
    for (int d = 1; d <= 4; d++) begin
      @(negedge clk);
      chk("t33_valid", plen_tvalid, 1);
      chk("t33_tdata", plen_tdata, d);
      chk("t33_tport", plen_tport, 1);
    end
    @(negedge clk);
    chk("t33_empty", plen_tvalid, 0);

    // full FIFO with pop and push in the same cycle
    enable = 1'b0;
    for (int d = 10; d <= 13; d++) begin
      drive(0, d, 0);
      @(negedge clk);
    end
    enable = 1'b1;
    drive(0, 77, 1);
    @(negedge clk); idle();
    chk("t34_drop0", drop_count[DW*0 +: DW], 0);
    chk("t34_first", plen_tdata, exp34[0]);
    for (int i = 1; i < 5; i++) begin
      @(negedge clk);
      chk("t34_order", plen_tdata, exp34[i]);
    end
    chk("t34_tuser", plen_tuser, 1);

    // drop counter saturation and clear priority
    clear_drops = 1'b1;
    @(negedge clk); idle();
    enable = 1'b0;
    for (int i = 0; i < 19; i++) begin
      drive(2, i, 0);
      @(negedge clk);
    end
    idle();
    chk("t35_at_max", drop_count[DW*2 +: DW], 15);
    for (int i = 0; i < 2; i++) begin
      drive(2, i, 0);
      @(negedge clk);
    end
    idle();
    chk("t35_sat", drop_count[DW*2 +: DW], 15);
    drive(2, 99, 0); clear_drops = 1'b1;
    @(negedge clk); idle();
    chk("t35_clear", drop_count[DW*2 +: DW], 0);
    enable = 1'b1;
    repeat (6) @(negedge clk);

    // mid-operation reset discards buffered entries
    enable = 1'b0;
    for (int d = 1; d <= 3; d++) begin
      drive(3, d, 0);
      @(negedge clk);
    end
    idle();
    resetn = 1'b0; enable = 1'b1;
    @(negedge clk);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t36_novalid", plen_tvalid, 0);
    end
    drive(3, 55, 0);
    @(negedge clk); idle();
    @(negedge clk);
    chk("t36_fresh_valid", plen_tvalid, 1);
    chk("t36_fresh_data", plen_tdata, 55);

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      if (c < 1500) in_tvalid = NP'($urandom & $urandom);
      else          in_tvalid = NP'($urandom);
      in_tuser    = NP'($urandom);
      in_tdata    = {$urandom, $urandom};
      enable      = ($urandom_range(0, 9) != 0);
      clear_drops = ($urandom_range(0, 99) == 0);
      resetn      = ($urandom_range(0, 499) != 0);
      @(negedge clk);
    end
    idle(); resetn = 1'b1; enable = 1'b1;
    repeat (12) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
